// File: rtl/fu_issue_fifo_bank.sv
// Per-functional-unit issue FIFO bank: steers up to IN_LANES issued packets per cycle
// into per-FU queues and presents each queue head to its FU under valid/ready.
module fu_issue_fifo_bank #(
  parameter int IN_LANES = 3,
  parameter int NUM_FU   = 8,
  parameter int DEPTH    = 4,
  parameter int PKT_W    = 64,
  parameter int SEL_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        squash,
  input  logic [IN_LANES-1:0]         in_valid,
  input  logic [IN_LANES*SEL_W-1:0]   in_fu_sel,
  input  logic [IN_LANES*PKT_W-1:0]   in_pkt,
  input  logic [NUM_FU-1:0]           fu_ready,
  output logic [NUM_FU-1:0]           fu_stall,
  output logic [NUM_FU-1:0]           out_valid,
  output logic [NUM_FU*PKT_W-1:0]     out_pkt,
  output logic [NUM_FU*CNT_W-1:0]     occupancy,
  output logic                        overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PKT_W-1:0] mem [NUM_FU][DEPTH];
  logic [PTR_W-1:0] head      [NUM_FU];
  logic [PTR_W-1:0] tail      [NUM_FU];
  logic [CNT_W-1:0] count     [NUM_FU];
  logic [PTR_W-1:0] head_nxt  [NUM_FU];
  logic [PTR_W-1:0] tail_nxt  [NUM_FU];
  logic [CNT_W-1:0] count_nxt [NUM_FU];
  logic [NUM_FU-1:0]   deq;
  logic [IN_LANES-1:0] lane_wr;
  logic [PTR_W-1:0]    lane_idx [IN_LANES];
  logic                drop;

  // Pointer addition modulo DEPTH; both operands are below DEPTH so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Steering: per FU, matching lanes take consecutive slots in lane order until space runs out.
  always_comb begin
    int acc;
    int space;
    drop = 1'b0;
    lane_wr = '0;
    for (int l = 0; l < IN_LANES; l++) lane_idx[l] = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      deq[f] = (count[f] != '0) && fu_ready[f];
      space  = DEPTH - int'(count[f]) + (deq[f] ? 1 : 0);
      acc    = 0;
      for (int l = 0; l < IN_LANES; l++) begin
        if (in_valid[l] && (int'(in_fu_sel[l*SEL_W +: SEL_W]) == f)) begin
          if (acc < space) begin
            lane_wr[l]  = 1'b1;
            lane_idx[l] = wrap_add(tail[f], acc);
            acc = acc + 1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      head_nxt[f]  = deq[f] ? wrap_add(head[f], 1) : head[f];
      tail_nxt[f]  = wrap_add(tail[f], acc);
      count_nxt[f] = CNT_W'(int'(count[f]) + acc - (deq[f] ? 1 : 0));
    end
    for (int l = 0; l < IN_LANES; l++) begin
      if (in_valid[l] && (int'(in_fu_sel[l*SEL_W +: SEL_W]) >= NUM_FU)) drop = 1'b1;
    end
  end

  // Control state: squash clears pointers but leaves the sticky error for rst alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      for (int f = 0; f < NUM_FU; f++) begin
        head[f]  <= '0;
        tail[f]  <= '0;
        count[f] <= '0;
      end
    end else begin
      if (drop) overflow_err <= 1'b1;
      for (int f = 0; f < NUM_FU; f++) begin
        if (squash) begin
          head[f]  <= '0;
          tail[f]  <= '0;
          count[f] <= '0;
        end else begin
          head[f]  <= head_nxt[f];
          tail[f]  <= tail_nxt[f];
          count[f] <= count_nxt[f];
        end
      end
    end
  end

  // Payload storage carries no reset; validity comes from the counts only.
  always_ff @(posedge clk) begin
    for (int l = 0; l < IN_LANES; l++) begin
      if (lane_wr[l]) mem[in_fu_sel[l*SEL_W +: SEL_W]][lane_idx[l]] <= in_pkt[l*PKT_W +: PKT_W];
    end
  end

  always_comb begin
    out_valid = '0;
    fu_stall  = '0;
    out_pkt   = '0;
    occupancy = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      out_valid[f] = (count[f] != '0);
      fu_stall[f]  = (int'(count[f]) > (DEPTH - IN_LANES));
      occupancy[f*CNT_W +: CNT_W] = count[f];
      if (count[f] != '0) out_pkt[f*PKT_W +: PKT_W] = mem[f][head[f]];
    end
  end

endmodule

// File: doc/fu_issue_fifo_bank.md
Name: fu_issue_fifo_bank

Overview:
Parametrised successor to the fixed 3-lane issue stage. It accepts up to IN_LANES issued RS packets per cycle and steers each one into a per-functional-unit FIFO. It presents the head packet of each FIFO to its FU under a valid/ready handshake. It adds configurable FU count and depth, multi-lane enqueue into the same FU in one cycle, per-FU stall and occupancy outputs, squash flush and sticky overflow detection. It sits between the RS/issue select logic and the FU array.

Parameters:
IN_LANES, 3, packets offered per cycle (superscalar width); 1 to NUM_FU.
NUM_FU, 8, number of FU channels (2**`SYS_FU_ADDR_WIDTH in the core).
DEPTH, 4, entries per FU FIFO; must be >= IN_LANES; need not be a power of 2.
PKT_W, 64, opaque payload width (packed ISSUE_FU_PACKET minus valid).
SEL_W, $clog2(NUM_FU), FU select width.
CNT_W, $clog2(DEPTH+1), occupancy width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
squash  in  1  flush all FIFOs (mispredict recovery).
in_valid  in  IN_LANES  lane i carries a packet.
in_fu_sel  in  IN_LANES*SEL_W  target FU index per lane.
in_pkt  in  IN_LANES*PKT_W  payload per lane.
fu_ready  in  NUM_FU  FU f accepts its head packet this cycle.
fu_stall  out  NUM_FU  FIFO f cannot guarantee IN_LANES free slots; RS must not send to f.
out_valid  out  NUM_FU  FIFO f non-empty.
out_pkt  out  NUM_FU*PKT_W  head payload of FIFO f.
occupancy  out  NUM_FU*CNT_W  registered entry count of FIFO f.
overflow_err  out  1  sticky: a packet was dropped for lack of space.

Behaviour:
- Reset (rst=1 at edge): all counts and pointers 0; out_valid=0, out_pkt=0, occupancy=0, overflow_err=0, fu_stall=0. rst has priority over squash and all traffic.
- Outputs are derived only from registered state, with no input-to-output combinational path. out_valid[f] = (count[f] != 0). out_pkt[f] = storage at head[f], and is 0 when the FIFO is empty. fu_stall[f] = (count[f] > DEPTH-IN_LANES).
- Dequeue: deq[f] = out_valid[f] & fu_ready[f]. At the edge, head[f] advances by one and wraps from DEPTH-1 to 0.
- Enqueue: for each FU f, the lanes with in_valid=1 and in_fu_sel=f are written in ascending lane order at tail[f], tail[f]+1, and so on, all modulo DEPTH.
  - Several lanes targeting one FU in the same cycle are all accepted if space allows.
  - An in_fu_sel >= NUM_FU is ignored and sets overflow_err.
- Capacity rule per FU: space = DEPTH - count + deq.
  - Enqueue and dequeue in the same cycle on a full FIFO is legal; the freed slot is reusable in that cycle.
  - If more lanes target f than space allows, the lowest-numbered lanes are accepted and the rest are dropped. overflow_err is set at that edge.
- Latency: a packet enqueued at edge k is visible on out_valid/out_pkt after edge k. There is no same-cycle bypass, so the minimum is one cycle.
- Ordering: strictly FIFO per FU, with lane order breaking ties within a cycle.
- count'[f] = count[f] + accepted[f] - deq[f]. It never exceeds DEPTH and never underflows.
- Squash (squash=1, rst=0) at an edge:
  - All counts, heads and tails are cleared.
  - Same-cycle enqueues are discarded.
  - Same-cycle dequeues still complete at the FU side (the FU saw valid&ready), but nothing is retained.
  - After the edge, out_valid=0 and fu_stall=0.
  - overflow_err is NOT cleared; only rst clears it.
- Storage contents need no reset. Only the pointers and counts define validity.

Test Plan:
- Basic steer: lanes 0/1/2 carry PC AAAA_AAAA→FU0, BBBB_BBBB→FU4, CCCC_CCCC→FU6, all fu_ready=1.
  - Next cycle: out_valid = 0b0101_0001 with matching out_pkt.
  - Cycle after: out_valid=0.
- Same-FU burst: 3 lanes → FU2 with payloads 1,2,3 and fu_ready[2]=0.
  - occupancy[2]=3, fu_stall[2]=1 (DEPTH=4).
  - Raise fu_ready: out_pkt[2] yields 1,2,3 on consecutive cycles, then out_valid[2]=0.
- Full with concurrent dequeue: fill FU1 to 4, then send 1 packet while fu_ready[1]=1.
  - Accepted; occupancy stays 4; overflow_err=0.
- Overflow: FU1 full with fu_ready=0, send 2 packets.
  - Both dropped, occupancy=4, overflow_err=1.
  - A following squash leaves overflow_err=1; rst clears it.
- Wrap-around: 10 single packets through FU3 with alternating fu_ready.
  - Output order equals input order across pointer wrap.
- Squash mid-operation: FU0 holds 2 entries, FU5 holds 1; assert squash together with a new lane-0 packet to FU0.
  - Next cycle: all out_valid=0, all occupancy=0, and the new packet is absent.
